sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Writer-side counterpart to the sprite image readers: copies a 50x50 palette-indexed sprite from a sprite ROM into the 640x480 palette-index framebuffer RAM at a given top-left (x, y).
- Sits between game logic (issues start plus position) and the framebuffer write port. The VGA path reads the framebuffer independently.
- Skips transparent pixels and clips pixels that fall off-screen.

Parameters:
- SPRITE_W, 50, sprite width in pixels
- SPRITE_H, 50, sprite height in pixels
- VIDEO_WIDTH, 640, framebuffer width
- VIDEO_HEIGHT, 480, framebuffer height
- SPRITE_ADDR_WIDTH, 13, sprite ROM address width ($clog2(SPRITE_W*SPRITE_H)+1)
- FB_ADDR_WIDTH, 20, framebuffer address width ($clog2(VIDEO_WIDTH*VIDEO_HEIGHT)+1)
- PALETTE_ADDRESS_WIDTH, 9, palette index width ($clog2(256)+1)
- TRANSPARENT, 9'd0, palette index that is never written

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request blit; sampled only in IDLE
- xPos  in  10  sprite top-left x
- yPos  in  9  sprite top-left y
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when blit completes
- spriteAddr  out  SPRITE_ADDR_WIDTH  sprite ROM read address
- spriteData  in  PALETTE_ADDRESS_WIDTH  sprite ROM data; synchronous, 1-cycle latency
- fbAddr  out  FB_ADDR_WIDTH  framebuffer write address
- fbData  out  PALETTE_ADDRESS_WIDTH  framebuffer write data
- fbWe  out  1  framebuffer write enable
- pixelsWritten  out  12  count of writes in the last/current blit

Behaviour:
- Reset (resetn=0, async):
  - state=IDLE.
  - busy, done, fbWe = 0.
  - spriteAddr, fbAddr, fbData, pixelsWritten = 0.
  - Reset mid-blit aborts immediately: no further writes and no done pulse.
- States: IDLE -> RUN -> DRAIN -> IDLE.
- IDLE:
  - On start=1 at edge E0: latch xPos/yPos, clear row/col counters and pixelsWritten, set busy=1, drive spriteAddr=0, go to RUN.
  - done=0 except during its single pulse cycle.
- RUN:
  - Each edge increments col (0..SPRITE_W-1); col wraps to 0 and row increments.
  - spriteAddr = row*SPRITE_W + col, one new address per cycle, 2500 addresses total.
  - After the edge issuing address 2499, go to DRAIN.
- Write pipeline:
  - Pixel k (address k) is issued at edge E0+k and returned by the ROM during cycle E0+k+1.
  - At edge E0+k+1 the write stage registers fbWe/fbAddr/fbData for pixel k, so fbWe for pixel k is visible during cycle E0+k+1..E0+k+2.
  - Row, col, and on-screen flags are delayed 1 cycle to align with spriteData.
- Write qualification: fbWe=1 only if all of the following hold:
  - spriteData != TRANSPARENT
  - (x+col) < VIDEO_WIDTH, computed in 11 bits with no wrap
  - (y+row) < VIDEO_HEIGHT, computed in 10 bits
  - Otherwise fbWe=0 and fbAddr/fbData hold their previous values.
- fbAddr = (y+row)*VIDEO_WIDTH + (x+col), computed at full FB_ADDR_WIDTH.
- pixelsWritten increments on every registered fbWe=1. It holds its value after done until the next accepted start.
- DRAIN:
  - One cycle to register the final write (pixel 2499 at edge E0+2500).
  - At edge E0+2501: busy=0, done=1 for exactly one cycle, state=IDLE.
- start while busy is ignored, with no queuing. start in the same cycle that done=1 is accepted; the next blit begins cleanly.
- xPos/yPos changes during a blit have no effect (latched values are used).
- Total latency is start edge to done high: 2501 cycles.

Test Plan:
- Opaque sprite (all index 5), xPos=100, yPos=50:
  - First write fbAddr=50*640+100=32100.
  - Last write fbAddr=99*640+149=63509.
  - pixelsWritten=2500; done pulses once at E0+2501.
- Checkerboard sprite (even addresses=0/TRANSPARENT, odd=7) at (0,0):
  - 1250 writes, all fbData=7, none at even-index positions; pixelsWritten=1250.
- Clipping, opaque sprite at xPos=620, yPos=460:
  - Only cols 0..19 and rows 0..19 are written: 400 writes.
  - Max fbAddr=479*640+639=307199; no write with x>=640.
- start held high through the whole blit and re-pulsed mid-blit:
  - Exactly one blit is performed; a second blit starts only at or after the done cycle.
- resetn pulled low at cycle E0+1000:
  - fbWe=0, busy=0 immediately; no done pulse.
  - After release, a new start performs a full, correct blit.
- Change xPos/yPos at E0+10:
  - All writes still use the latched position; fbAddr sequence matches the original (x, y).

Source files
------------

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a SPRITE_W x SPRITE_H palette-indexed sprite from ROM into the
// framebuffer at a latched (x, y), skipping transparent pixels and clipping off-screen ones.
module sprite_blitter #(
    parameter int unsigned SPRITE_W              = 50,
    parameter int unsigned SPRITE_H              = 50,
    parameter int unsigned VIDEO_WIDTH           = 640,
    parameter int unsigned VIDEO_HEIGHT          = 480,
    parameter int unsigned SPRITE_ADDR_WIDTH     = 13,
    parameter int unsigned FB_ADDR_WIDTH         = 20,
    parameter int unsigned PALETTE_ADDRESS_WIDTH = 9,
    parameter logic [PALETTE_ADDRESS_WIDTH-1:0] TRANSPARENT = '0
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             start,
    input  logic [9:0]                       xPos,
    input  logic [8:0]                       yPos,
    output logic                             busy,
    output logic                             done,
    output logic [SPRITE_ADDR_WIDTH-1:0]     spriteAddr,
    input  logic [PALETTE_ADDRESS_WIDTH-1:0] spriteData,
    output logic [FB_ADDR_WIDTH-1:0]         fbAddr,
    output logic [PALETTE_ADDRESS_WIDTH-1:0] fbData,
    output logic                             fbWe,
    output logic [11:0]                      pixelsWritten
);

    localparam int unsigned SPRITE_PIXELS = SPRITE_W * SPRITE_H;
    localparam int unsigned COL_W         = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int unsigned ROW_W         = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                           state_q, state_d;
    logic [9:0]                       x_q, x_d;
    logic [8:0]                       y_q, y_d;
    logic [COL_W-1:0]                 col_q, col_d;
    logic [ROW_W-1:0]                 row_q, row_d;
    logic [SPRITE_ADDR_WIDTH-1:0]     spriteAddr_q, spriteAddr_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    logic                             drain_q, drain_d;
    logic                             issue;
    logic                             clear_cnt;

    // Pipeline stage holding placement of the pixel whose ROM data is on spriteData.
    logic                             pv_q, pv_d;
    logic                             pon_q, pon_d;
    logic [FB_ADDR_WIDTH-1:0]         paddr_q, paddr_d;

    logic                             fbWe_q, fbWe_d;
    logic [FB_ADDR_WIDTH-1:0]         fbAddr_q, fbAddr_d;
    logic [PALETTE_ADDRESS_WIDTH-1:0] fbData_q, fbData_d;
    logic [11:0]                      pixelsWritten_q, pixelsWritten_d;

    logic [10:0]                      sx;
    logic [9:0]                       sy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            x_q             <= '0;
            y_q             <= '0;
            col_q           <= '0;
            row_q           <= '0;
            spriteAddr_q    <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            drain_q         <= 1'b0;
            pv_q            <= 1'b0;
            pon_q           <= 1'b0;
            paddr_q         <= '0;
            fbWe_q          <= 1'b0;
            fbAddr_q        <= '0;
            fbData_q        <= '0;
            pixelsWritten_q <= '0;
        end else begin
            state_q         <= state_d;
            x_q             <= x_d;
            y_q             <= y_d;
            col_q           <= col_d;
            row_q           <= row_d;
            spriteAddr_q    <= spriteAddr_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            drain_q         <= drain_d;
            pv_q            <= pv_d;
            pon_q           <= pon_d;
            paddr_q         <= paddr_d;
            fbWe_q          <= fbWe_d;
            fbAddr_q        <= fbAddr_d;
            fbData_q        <= fbData_d;
            pixelsWritten_q <= pixelsWritten_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        col_d        = col_q;
        row_d        = row_q;
        spriteAddr_d = spriteAddr_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        drain_d      = drain_q;
        issue        = 1'b0;
        clear_cnt    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d          = xPos;
                    y_d          = yPos;
                    col_d        = '0;
                    row_d        = '0;
                    spriteAddr_d = '0;
                    busy_d       = 1'b1;
                    drain_d      = 1'b0;
                    issue        = 1'b1;
                    clear_cnt    = 1'b1;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (col_q == COL_W'(SPRITE_W - 1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                spriteAddr_d = spriteAddr_q + 1'b1;
                issue        = 1'b1;
                if (spriteAddr_q == SPRITE_ADDR_WIDTH'(SPRITE_PIXELS - 2)) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            DRAIN: begin
                // First DRAIN edge registers the final write; second raises done.
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else begin
                    drain_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                drain_d = 1'b0;
            end
        endcase
    end

    // Placement is computed from the coordinates of the address being issued this edge.
    always_comb begin
        sx      = {1'b0, x_d} + 11'(col_d);
        sy      = {1'b0, y_d} + 10'(row_d);
        pv_d    = issue;
        pon_d   = (sx < 11'(VIDEO_WIDTH)) && (sy < 10'(VIDEO_HEIGHT));
        paddr_d = FB_ADDR_WIDTH'(sy) * FB_ADDR_WIDTH'(VIDEO_WIDTH) + FB_ADDR_WIDTH'(sx);
    end

    always_comb begin
        fbWe_d          = pv_q && pon_q && (spriteData != TRANSPARENT);
        fbAddr_d        = fbWe_d ? paddr_q : fbAddr_q;
        fbData_d        = fbWe_d ? spriteData : fbData_q;
        pixelsWritten_d = clear_cnt ? '0 : pixelsWritten_q + 12'(fbWe_d);
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign spriteAddr    = spriteAddr_q;
    assign fbAddr        = fbAddr_q;
    assign fbData        = fbData_q;
    assign fbWe          = fbWe_q;
    assign pixelsWritten = pixelsWritten_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: behavioural ROM, expected-write table per blit,
// and a negedge monitor comparing every framebuffer write against that table.
module tb_sprite_blitter;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [9:0]  xPos;
    logic [8:0]  yPos;
    logic        busy;
    logic        done;
    logic [12:0] spriteAddr;
    logic [8:0]  spriteData;
    logic [19:0] fbAddr;
    logic [8:0]  fbData;
    logic        fbWe;
    logic [11:0] pixelsWritten;

    sprite_blitter #(
        .SPRITE_W(50),
        .SPRITE_H(50),
        .VIDEO_WIDTH(640),
        .VIDEO_HEIGHT(480),
        .SPRITE_ADDR_WIDTH(13),
        .FB_ADDR_WIDTH(20),
        .PALETTE_ADDRESS_WIDTH(9)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .start(start),
        .xPos(xPos),
        .yPos(yPos),
        .busy(busy),
        .done(done),
        .spriteAddr(spriteAddr),
        .spriteData(spriteData),
        .fbAddr(fbAddr),
        .fbData(fbData),
        .fbWe(fbWe),
        .pixelsWritten(pixelsWritten)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: mode 0 = all index 5, mode 1 = even addresses transparent, odd = 7.
    int rom_mode;
    always_comb begin
        if (rom_mode == 0) spriteData = 9'd5;
        else               spriteData = spriteAddr[0] ? 9'd7 : 9'd0;
    end

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int exp_addr[2500];
    int exp_data[2500];
    int exp_n;
    int wr_n;
    int mism;
    int done_cnt;
    int max_addr;
    int first_addr;
    int last_addr;

    always @(negedge clk) begin
        if (fbWe) begin
            if (wr_n < exp_n) begin
                if (int'(fbAddr) != exp_addr[wr_n] || int'(fbData) != exp_data[wr_n]) mism++;
            end else begin
                mism++;
            end
            if (wr_n == 0) first_addr = int'(fbAddr);
            last_addr = int'(fbAddr);
            if (int'(fbAddr) > max_addr) max_addr = int'(fbAddr);
            wr_n++;
        end
        if (done) done_cnt++;
    end

    task automatic build_expect(input int x, input int y, input int mode);
        exp_n = 0;
        for (int k = 0; k < 2500; k++) begin
            int row, col, d;
            row = k / 50;
            col = k % 50;
            d   = (mode == 0) ? 5 : ((k % 2 == 1) ? 7 : 0);
            if (d != 0 && (x + col) < 640 && (y + row) < 480) begin
                exp_addr[exp_n] = (y + row) * 640 + (x + col);
                exp_data[exp_n] = d;
                exp_n++;
            end
        end
    endtask

    // Called with the clock just past a rising edge; starts a blit at the next edge.
    task automatic run_blit(input string tag, input int x, input int y, input int mode,
                            input bit hold, input bit move);
        int cyc;
        bit seen;
        build_expect(x, y, mode);
        rom_mode = mode;
        xPos  = 10'(x);
        yPos  = 9'(y);
        start = 1'b1;
        @(posedge clk);
        #1;
        wr_n = 0; mism = 0; done_cnt = 0; max_addr = -1; first_addr = -1; last_addr = -1;
        check_eq({tag, "_busy_on_start"}, int'(busy), 1);
        if (!hold) start = 1'b0;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (move && cyc == 10) begin
                xPos = 10'd300;
                yPos = 9'd200;
            end
            if (hold && cyc == 1000) start = 1'b0;
            if (hold && cyc == 1001) start = 1'b1;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, cyc, 2501);
        check_eq({tag, "_busy_at_done"}, int'(busy), 0);
        @(negedge clk);
        #1;
        check_eq({tag, "_done_pulses"}, done_cnt, 1);
        check_eq({tag, "_writes"}, wr_n, exp_n);
        check_eq({tag, "_seq_mismatch"}, mism, 0);
        check_eq({tag, "_pixelsWritten"}, int'(pixelsWritten), exp_n);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rom_mode = 0; exp_n = 0; wr_n = 0; mism = 0; done_cnt = 0;
        max_addr = -1; first_addr = -1; last_addr = -1;
        resetn = 1'b0; start = 1'b0; xPos = '0; yPos = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_fbWe", int'(fbWe), 0);
        check_eq("rst_spriteAddr", int'(spriteAddr), 0);
        check_eq("rst_fbAddr", int'(fbAddr), 0);
        check_eq("rst_fbData", int'(fbData), 0);
        check_eq("rst_pixelsWritten", int'(pixelsWritten), 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_blit("opaque", 100, 50, 0, 1'b0, 1'b0);
        check_eq("opaque_first_addr", first_addr, 32100);
        check_eq("opaque_last_addr", last_addr, 63509);
        check_eq("opaque_count", int'(pixelsWritten), 2500);

        // Starts within the previous done cycle.
        run_blit("checker", 0, 0, 1, 1'b0, 1'b0);
        check_eq("checker_count", int'(pixelsWritten), 1250);
        check_eq("checker_last_data", int'(fbData), 7);

        run_blit("clip", 620, 460, 0, 1'b0, 1'b0);
        check_eq("clip_count", int'(pixelsWritten), 400);
        check_eq("clip_max_addr", max_addr, 307199);

        run_blit("hold", 200, 100, 0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_eq("hold_no_restart", int'(busy), 0);
        check_eq("hold_count_kept", int'(pixelsWritten), 2500);

        run_blit("move", 40, 30, 0, 1'b0, 1'b1);
        check_eq("move_first_addr", first_addr, 30 * 640 + 40);
        check_eq("move_last_addr", last_addr, 79 * 640 + 89);
        @(posedge clk);
        #1;

        // Abort mid-blit with reset.
        build_expect(100, 50, 0);
        rom_mode = 0;
        xPos = 10'd100; yPos = 9'd50;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0;
        repeat (1000) @(posedge clk);
        #1;
        check_eq("abort_busy_before", int'(busy), 1);
        resetn = 1'b0;
        #1;
        check_eq("abort_fbWe", int'(fbWe), 0);
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_pixelsWritten", int'(pixelsWritten), 0);
        repeat (4) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_cnt, 0);
        check_eq("abort_idle", int'(busy), 0);

        run_blit("after_rst", 10, 20, 0, 1'b0, 1'b0);
        check_eq("after_rst_first_addr", first_addr, 20 * 640 + 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
